// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Parameters: WIDTH (operand bits, >=2), DIGITS (BCD digits, >=1).
// Ports: clk, rst (async active-high), start/bin (request and operand),
//        busy (converting), done (one-cycle result pulse), bcd (digit k at bcd[4k+3:4k]),
//        overflow (value exceeded DIGITS digits), sign (negative operand, signed mode).
// Optional: define BIN2BCD_SIGNED_EN to treat bin as two's complement.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  sign
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                state;
  logic [WIDTH-1:0]      sr, nxt_sr, mag;
  logic [4*DIGITS-1:0]   dig, adj, nxt_dig;
  logic [CW-1:0]         cnt;
  logic                  ovf, cout, sgn_in, sgn_r;
`ifdef BIN2BCD_SIGNED_EN
  // Magnitude as unsigned WIDTH bits, so the most negative value converts correctly.
  assign sgn_in = bin[WIDTH-1];
  assign mag    = sgn_in ? -bin : bin;
`else
  assign sgn_in = 1'b0;
  assign mag    = bin;
`endif
  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    assign adj[4*k+:4] = dig[4*k+:4] >= 4'd5 ? dig[4*k+:4] + 4'd3 : dig[4*k+:4];
  end
  // The bit shifted out of the top digit marks a value beyond DIGITS digits.
  assign {cout, nxt_dig, nxt_sr} = {adj, sr, 1'b0};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      sign     <= 1'b0;
      sr       <= '0;
      dig      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      sgn_r    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == SHIFT) begin
        sr  <= nxt_sr;
        dig <= nxt_dig;
        ovf <= ovf | cout;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          bcd      <= nxt_dig;
          overflow <= ovf | cout;
          sign     <= sgn_r;
        end
      end else if (start) begin
        state <= SHIFT;
        busy  <= 1'b1;
        sr    <= mag;
        dig   <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
        sgn_r <= sgn_in;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
